// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath:
// run/fetch inputs, bus-driver strobes, register selects and load strobes.
interface alu_instr_sequencer_if #(
  parameter int OPW = 5
) ();
  // Inputs to the sequencer
  logic           Start;
  logic [OPW-1:0] Opcode;
  logic           Mem_Ready;
  // Bus-driver strobes (at most one high per cycle)
  logic PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, Rout;
  // Register-field selects
  logic Gra, Grb, Grc;
  // Load strobes
  logic MAR_In, PC_In, IR_In, MDR_In, Y_In, Z_In, HI_In, LO_In, Rin;
  // Memory / ALU control and status
  logic           Read, IncPC;
  logic [OPW-1:0] ALU_Op;
  logic           Busy, Done, Illegal;

  modport master (
    input  Start, Opcode, Mem_Ready,
    output PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, Rout,
    output Gra, Grb, Grc,
    output MAR_In, PC_In, IR_In, MDR_In, Y_In, Z_In, HI_In, LO_In, Rin,
    output Read, IncPC, ALU_Op, Busy, Done, Illegal
  );

  modport slave (
    output Start, Opcode, Mem_Ready,
    input  PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, Rout,
    input  Gra, Grb, Grc,
    input  MAR_In, PC_In, IR_In, MDR_In, Y_In, Z_In, HI_In, LO_In, Rin,
    input  Read, IncPC, ALU_Op, Busy, Done, Illegal
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU ops on a
// single shared bus. Every state drives at most one bus source, so the
// priority bus mux downstream never sees competing drivers.
module alu_instr_sequencer #(
  parameter int OPW         = 5,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    clear_n,
  alu_instr_sequencer_if.master   bus
);

  localparam int CW = $clog2(RDY_TIMEOUT + 1);
  // Last wait count before giving up on memory
  localparam logic [CW-1:0] TO_LAST = CW'(RDY_TIMEOUT - 1);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_SHR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR = OPW'(6);
  localparam logic [OPW-1:0] OP_ROL = OPW'(7);
  localparam logic [OPW-1:0] OP_MUL = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT = OPW'(18);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            illegal_q, illegal_d;

  function automatic logic is_binary(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                      OP_ROR, OP_ROL, OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_unary(input logic [OPW-1:0] op);
    return op inside {OP_NEG, OP_NOT};
  endfunction

  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  // Next-state: sequencing, memory wait counting and error detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.Start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (bus.Mem_Ready) begin
          state_d = S_T2;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        // Latch the opcode so T4/T5 don't depend on IR staying put
        op_d = bus.Opcode;
        if (is_binary(bus.Opcode))     state_d = S_T4;
        else if (is_unary(bus.Opcode)) state_d = S_T5;
        else begin
          state_d   = S_IDLE;
          illegal_d = 1'b1;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_muldiv(op_q) ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter, latched opcode and the registered Illegal pulse
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore strobe decode; T3 additionally looks at the live opcode
  always_comb begin
    bus.PC_Out  = 1'b0; bus.MDR_Out = 1'b0; bus.ZHI_Out = 1'b0;
    bus.ZLO_Out = 1'b0; bus.HI_Out  = 1'b0; bus.LO_Out  = 1'b0;
    bus.Rout    = 1'b0;
    bus.Gra     = 1'b0; bus.Grb     = 1'b0; bus.Grc     = 1'b0;
    bus.MAR_In  = 1'b0; bus.PC_In   = 1'b0; bus.IR_In   = 1'b0;
    bus.MDR_In  = 1'b0; bus.Y_In    = 1'b0; bus.Z_In    = 1'b0;
    bus.HI_In   = 1'b0; bus.LO_In   = 1'b0; bus.Rin     = 1'b0;
    bus.Read    = 1'b0; bus.IncPC   = 1'b0;
    bus.ALU_Op  = '0;
    bus.Busy    = (state_q != S_IDLE);
    bus.Done    = (state_q == S_DONE);
    bus.Illegal = illegal_q;
    unique case (state_q)
      S_T0: begin
        bus.PC_Out = 1'b1; bus.MAR_In = 1'b1; bus.IncPC = 1'b1; bus.Z_In = 1'b1;
      end
      S_T1: begin
        // PC only reloads on the first wait cycle; Z already holds PC+1
        bus.ZLO_Out = 1'b1; bus.Read = 1'b1; bus.MDR_In = 1'b1;
        bus.PC_In   = (cnt_q == '0);
      end
      S_T2: begin
        bus.MDR_Out = 1'b1; bus.IR_In = 1'b1;
      end
      S_T3: begin
        if (is_binary(bus.Opcode)) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_In = 1'b1;
        end else if (is_unary(bus.Opcode)) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_In = 1'b1;
          bus.ALU_Op = bus.Opcode;
        end
      end
      S_T4: begin
        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Z_In = 1'b1; bus.ALU_Op = op_q;
      end
      S_T5: begin
        bus.ZLO_Out = 1'b1;
        if (is_muldiv(op_q)) bus.LO_In = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.ZHI_Out = 1'b1; bus.HI_In = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
